// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_pkg
// Purpose  : Shared definitions for the UART frame controller:
//            - frame state encoding (IDLE, CMD, LEN, PAYLOAD, CSUM)
//            - error code constants reported on err_code
//            - default frame start marker
//            - helper that sizes the inter-byte timeout counter
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // Width of a counter that must reach cycles-1; never narrower than 1 bit.
    function automatic int tmo_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_strobe.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_strobe
// Purpose  : Turns the level-style rx_sample from the UART byte receiver into
//            a single-cycle byte accept. One accept per rising edge of
//            rx_sample, no matter how long the level stays high.
// Ports    : clk        in   system clock
//            rst        in   asynchronous active-high reset
//            rx_sample  in   byte-valid level from the receiver
//            rx_data    in   received byte
//            byte_acc   out  one-cycle accept (rx_sample high, previous low)
//            byte_data  out  byte to capture in the accept cycle
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_strobe (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_sample,
    input  logic [7:0] rx_data,
    output logic       byte_acc,
    output logic [7:0] byte_data
);

    logic r_rx_prev;

    // The previous level resets high so that a rx_sample already asserted
    // when reset releases is not mistaken for a fresh byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= rx_sample;
        end
    end

    assign byte_acc  = rx_sample & ~r_rx_prev;
    assign byte_data = rx_data;

endmodule
`default_nettype wire

// File: rtl/uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_ctrl
// Purpose  : Frame-level controller behind the UART byte receiver. Sequences
//            accepted bytes through SYNC, CMD, LEN, LEN payload bytes, CSUM;
//            writes payload into a downstream buffer and reports each frame
//            as done or errored. An inter-byte timeout returns a stalled
//            frame to IDLE. CSUM is the XOR of CMD, LEN and all payload bytes.
// Ports    : clk, rst           clock / asynchronous active-high reset
//            rx_data, rx_sample byte from receiver, valid-level strobe
//            pay_we/addr/wdata  payload buffer write port
//            frame_done         one-cycle pulse, good frame
//            frame_cmd/len      CMD / LEN of the last good frame
//            frame_err          one-cycle pulse, frame aborted
//            err_code           01 bad LEN, 10 checksum, 11 timeout
//            busy               high whenever a frame is in progress
// Options  : UART_FRAME_CTRL_STATS_EN adds saturating stat_ok / stat_err
//            counters of frame_done / frame_err pulses.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_ctrl
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_W         = 4,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_sample,
    output logic              pay_we,
    output logic [ADDR_W-1:0] pay_addr,
    output logic [7:0]        pay_wdata,
    output logic              frame_done,
    output logic [7:0]        frame_cmd,
    output logic [7:0]        frame_len,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
`ifdef UART_FRAME_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_ok,
    output logic [15:0]       stat_err
`endif
);

    localparam int                 c_tmo_w    = tmo_width(TIMEOUT_CYCLES);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmo_w-1:0] c_tmo_one  = c_tmo_w'(1);
    localparam logic [8:0]         c_max_len  = 9'(MAX_LEN);

    logic               w_acc;
    logic [7:0]         w_byte;

    state_t             r_state;
    logic [7:0]         r_cmd;
    logic [7:0]         r_len;
    logic [7:0]         r_idx;
    logic [7:0]         r_csum;
    logic [c_tmo_w-1:0] r_tmo;

    uart_byte_strobe u_strobe (
        .clk       (clk),
        .rst       (rst),
        .rx_sample (rx_sample),
        .rx_data   (rx_data),
        .byte_acc  (w_acc),
        .byte_data (w_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cmd      <= 8'd0;
            r_len      <= 8'd0;
            r_idx      <= 8'd0;
            r_csum     <= 8'd0;
            r_tmo      <= '0;
            pay_we     <= 1'b0;
            pay_addr   <= '0;
            pay_wdata  <= 8'd0;
            frame_done <= 1'b0;
            frame_cmd  <= 8'd0;
            frame_len  <= 8'd0;
            frame_err  <= 1'b0;
            err_code   <= 2'b00;
            busy       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            pay_we     <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;

            if (r_state == ST_IDLE) begin
                r_tmo <= '0;
                // Anything other than the marker is line noise between frames.
                if (w_acc && (w_byte == SYNC_BYTE)) begin
                    r_state <= ST_CMD;
                    busy    <= 1'b1;
                end
            end else if (w_acc) begin
                // An accept always wins over a coincident timeout terminal count.
                r_tmo <= '0;
                case (r_state)
                    ST_CMD: begin
                        r_cmd   <= w_byte;
                        r_csum  <= w_byte;
                        r_state <= ST_LEN;
                    end
                    ST_LEN: begin
                        if ({1'b0, w_byte} > c_max_len) begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_LEN;
                            r_state   <= ST_IDLE;
                            busy      <= 1'b0;
                        end else begin
                            r_len   <= w_byte;
                            r_csum  <= r_csum ^ w_byte;
                            r_idx   <= 8'd0;
                            r_state <= (w_byte == 8'd0) ? ST_CSUM : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        pay_we    <= 1'b1;
                        pay_addr  <= ADDR_W'(r_idx);
                        pay_wdata <= w_byte;
                        r_csum    <= r_csum ^ w_byte;
                        r_idx     <= r_idx + 8'd1;
                        if ((r_idx + 8'd1) == r_len) begin
                            r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (w_byte == r_csum) begin
                            frame_done <= 1'b1;
                            frame_cmd  <= r_cmd;
                            frame_len  <= r_len;
                        end else begin
                            frame_err <= 1'b1;
                            err_code  <= ERR_CSUM;
                        end
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end else if (r_tmo == c_tmo_last) begin
                frame_err <= 1'b1;
                err_code  <= ERR_TIMEOUT;
                r_tmo     <= '0;
                r_state   <= ST_IDLE;
                busy      <= 1'b0;
            end else begin
                r_tmo <= r_tmo + c_tmo_one;
            end
        end
    end

`ifdef UART_FRAME_CTRL_STATS_EN
    // Counters follow the registered pulses, so they settle one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ok  <= 16'd0;
            stat_err <= 16'd0;
        end else begin
            if (frame_done && (stat_ok != 16'hFFFF)) begin
                stat_ok <= stat_ok + 16'd1;
            end
            if (frame_err && (stat_err != 16'hFFFF)) begin
                stat_err <= stat_err + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_ctrl
// Purpose  : Self-checking bench for uart_frame_ctrl. A frame-level reference
//            model (byte queue per frame, idle-cycle count since the last
//            byte) predicts every output each cycle; directed frames plus
//            literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         ADDR_W  = 4;
    localparam int         TMO     = 64;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        rx_data;
    logic              rx_sample;
    logic              pay_we;
    logic [ADDR_W-1:0] pay_addr;
    logic [7:0]        pay_wdata;
    logic              frame_done;
    logic [7:0]        frame_cmd;
    logic [7:0]        frame_len;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;
`ifdef UART_FRAME_CTRL_STATS_EN
    logic [15:0]       stat_ok;
    logic [15:0]       stat_err;
`endif

    uart_frame_ctrl #(
        .MAX_LEN        (MAX_LEN),
        .ADDR_W         (ADDR_W),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_sample  (rx_sample),
        .pay_we     (pay_we),
        .pay_addr   (pay_addr),
        .pay_wdata  (pay_wdata),
        .frame_done (frame_done),
        .frame_cmd  (frame_cmd),
        .frame_len  (frame_len),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy)
`ifdef UART_FRAME_CTRL_STATS_EN
        ,
        .stat_ok    (stat_ok),
        .stat_err   (stat_err)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]        fb[$];      // bytes of the frame in progress, SYNC first
    bit                m_prev;
    int                m_idle;
    logic              e_we, e_done, e_err, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_wdata, e_cmd, e_len;
    logic [1:0]        e_code;

    int         obs_done = 0;
    int         obs_err  = 0;
    int         obs_we   = 0;
    logic [7:0] wr_mem [16];

    task automatic model_reset();
        fb.delete();
        m_prev  = 1'b1;
        m_idle  = 0;
        e_we    = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        e_busy  = 1'b0;
        e_addr  = '0;
        e_wdata = 8'd0;
        e_cmd   = 8'd0;
        e_len   = 8'd0;
        e_code  = 2'b00;
    endtask

    // Predicts the outputs visible after the next rising edge.
    task automatic model_step(input logic s, input logic [7:0] d);
        bit         acc;
        int         n;
        logic [7:0] x;
        acc    = s && !m_prev;
        m_prev = s;
        e_we   = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (acc) begin
            m_idle = 0;
            if (fb.size() == 0) begin
                if (d == SYNC) fb.push_back(d);
            end else begin
                fb.push_back(d);
                n = fb.size();
                if (n == 3 && int'(d) > MAX_LEN) begin
                    e_err  = 1'b1;
                    e_code = 2'b01;
                    fb.delete();
                end else if (n >= 4) begin
                    if (n <= 3 + int'(fb[2])) begin
                        e_we    = 1'b1;
                        e_addr  = ADDR_W'(n - 4);
                        e_wdata = d;
                    end else begin
                        x = 8'd0;
                        for (int i = 1; i < n - 1; i++) x = x ^ fb[i];
                        if (x == d) begin
                            e_done = 1'b1;
                            e_cmd  = fb[1];
                            e_len  = fb[2];
                        end else begin
                            e_err  = 1'b1;
                            e_code = 2'b10;
                        end
                        fb.delete();
                    end
                end
            end
        end else if (fb.size() != 0) begin
            m_idle++;
            if (m_idle == TMO) begin
                e_err  = 1'b1;
                e_code = 2'b11;
                fb.delete();
            end
        end
        e_busy = (fb.size() != 0);
    endtask

    // Compare on the falling edge, then advance the model for the next edge.
    always @(negedge clk) begin
        if (rst) model_reset();
        chk("pay_we", pay_we, e_we);
        if (e_we) begin
            chk("pay_addr", pay_addr, e_addr);
            chk("pay_wdata", pay_wdata, e_wdata);
        end
        chk("frame_done", frame_done, e_done);
        chk("frame_err", frame_err, e_err);
        chk("err_code", err_code, e_code);
        chk("frame_cmd", frame_cmd, e_cmd);
        chk("frame_len", frame_len, e_len);
        chk("busy", busy, e_busy);
        if (pay_we === 1'b1) begin
            obs_we++;
            wr_mem[int'(pay_addr)] = pay_wdata;
        end
        if (frame_done === 1'b1) obs_done++;
        if (frame_err === 1'b1) obs_err++;
        if (!rst) model_step(rx_sample, rx_data);
    end

    // ---------------- stimulus ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        rx_data   = b;
        rx_sample = 1'b1;
        idle(hold);
        rx_sample = 1'b0;
        idle(1);
    endtask

    task automatic send_seq(input logic [7:0] bytes[$], input int hold);
        foreach (bytes[i]) send(bytes[i], hold);
    endtask

    int we0;

    initial begin
        rst       = 1'b1;
        rx_sample = 1'b0;
        rx_data   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        chk("reset_busy", busy, 0);
        chk("reset_cmd", frame_cmd, 0);
        chk("reset_code", err_code, 0);

        // Noise between frames is dropped silently.
        send(8'h55, 1);
        chk("noise_busy", busy, 0);
        chk("noise_err", obs_err, 0);

        // Good frame; 10^03^11^22^33 = 0x13.
        send_seq('{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13}, 1);
        chk("A_cmd", frame_cmd, 8'h10);
        chk("A_len", frame_len, 8'h03);
        chk("A_code", err_code, 2'b00);
        chk("A_we_cnt", obs_we, 3);
        chk("A_mem0", wr_mem[0], 8'h11);
        chk("A_mem1", wr_mem[1], 8'h22);
        chk("A_mem2", wr_mem[2], 8'h33);
        chk("A_done", obs_done, 1);

        // Zero-length frame.
        we0 = obs_we;
        send_seq('{8'hA5, 8'h7E, 8'h00, 8'h7E}, 1);
        chk("Z_no_we", obs_we, we0);
        chk("Z_len", frame_len, 8'h00);
        chk("Z_cmd", frame_cmd, 8'h7E);
        chk("Z_done", obs_done, 2);

        // LEN above MAX_LEN, then a good frame.
        send_seq('{8'hA5, 8'h05, 8'h11}, 1);
        chk("L_code", err_code, 2'b01);
        chk("L_err", obs_err, 1);
        send_seq('{8'hA5, 8'h01, 8'h00, 8'h01}, 1);
        chk("L2_done", obs_done, 3);
        chk("L2_cmd", frame_cmd, 8'h01);

        // Wrong checksum (correct would be 0x44).
        we0 = obs_we;
        send_seq('{8'hA5, 8'h10, 8'h01, 8'h55, 8'h00}, 1);
        chk("C_we_cnt", obs_we, we0 + 1);
        chk("C_mem0", wr_mem[0], 8'h55);
        chk("C_code", err_code, 2'b10);
        chk("C_err", obs_err, 2);
        chk("C_no_done", obs_done, 3);

        // SYNC byte inside the payload is plain data; csum 22^02^A5^5A = DF.
        send_seq('{8'hA5, 8'h22, 8'h02, 8'hA5, 8'h5A, 8'hDF}, 1);
        chk("S_done", obs_done, 4);
        chk("S_mem0", wr_mem[0], 8'hA5);
        chk("S_mem1", wr_mem[1], 8'h5A);

        // Timeout after CMD.
        send_seq('{8'hA5, 8'h20}, 1);
        idle(TMO + 4);
        chk("T_code", err_code, 2'b11);
        chk("T_err", obs_err, 3);
        chk("T_busy", busy, 0);

        // Next byte lands exactly on the terminal-count cycle.
        send_seq('{8'hA5, 8'h30}, 1);
        idle(TMO - 2);
        send_seq('{8'h00, 8'h30}, 1);
        chk("TE_done", obs_done, 5);
        chk("TE_err", obs_err, 3);
        chk("TE_cmd", frame_cmd, 8'h30);

        // rx_sample held for 8 cycles per byte; csum 40^01^77 = 36.
        we0 = obs_we;
        send_seq('{8'hA5, 8'h40, 8'h01, 8'h77, 8'h36}, 8);
        chk("H_done", obs_done, 6);
        chk("H_we_cnt", obs_we, we0 + 1);
        chk("H_mem0", wr_mem[0], 8'h77);
`ifdef UART_FRAME_CTRL_STATS_EN
        chk("stat_ok_pre", stat_ok, 16'd6);
        chk("stat_err_pre", stat_err, 16'd3);
`endif

        // Reset in the middle of the payload with rx_sample high.
        we0 = obs_we;
        send_seq('{8'hA5, 8'h60, 8'h04, 8'h11}, 8);
        rx_data   = 8'h22;
        rx_sample = 1'b1;
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(4);
        chk("R_we_cnt", obs_we, we0 + 2);
        chk("R_busy", busy, 0);
        chk("R_cmd", frame_cmd, 8'h00);
        chk("R_no_pulse", obs_done + obs_err, 9);
        rx_sample = 1'b0;
        idle(1);
        send_seq('{8'hA5, 8'h50, 8'h00, 8'h50}, 1);
        chk("R2_done", obs_done, 7);
        chk("R2_cmd", frame_cmd, 8'h50);
`ifdef UART_FRAME_CTRL_STATS_EN
        idle(1);
        chk("stat_ok_post", stat_ok, 16'd1);
        chk("stat_err_post", stat_err, 16'd0);
`endif

        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
